// File: rtl/div_clk_arbiter.sv
// div_clk_arbiter: round-robin owner of a shared clock divider.
// Grants one requester at a time a divide count for a fixed hold time.
module div_clk_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CW      = 32,
   parameter int DW      = 32
) (
   input  logic                  inclk,
   input  logic                  Reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*CW-1:0] req_div_count,
   input  logic [NUM_REQ*DW-1:0] req_duration,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic [CW-1:0]         div_clk_count,
   output logic                  div_run_n_reset
);

   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DW-1:0]        dur_q, dur_d;
   logic [LW-1:0]        last_q, last_d;
   logic                 run_q, run_d;
   logic                 win_vld;
   logic [LW-1:0]        win;
   logic                 owner_req;
   int                   cand;

   assign owner_req = |(req & grant_q);

   // round-robin search upward from the previous owner, wrapping
   always_comb begin
      win_vld = 1'b0;
      win     = last_q;
      cand    = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(last_q) + i) % NUM_REQ;
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win     = LW'(cand);
         end
      end
   end

   // next-state: arbitrate in IDLE, one LOAD cycle, then timed RUN
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      last_d  = last_q;
      run_d   = run_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d     = S_LOAD;
               grant_d     = '0;
               grant_d[win] = 1'b1;
               cnt_d       = req_div_count[int'(win)*CW +: CW];
               dur_d       = req_duration[int'(win)*DW +: DW];
               last_d      = win;
               run_d       = 1'b0;
            end
         end
         S_LOAD: begin
            if (!owner_req) begin
               state_d = S_IDLE;
               grant_d = '0;
               run_d   = 1'b0;
            end else begin
               state_d = S_RUN;
               run_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (!owner_req) begin
               state_d = S_IDLE;
               grant_d = '0;
               run_d   = 1'b0;
            end else if (dur_q <= DW'(1)) begin
               state_d = S_IDLE;
               done_d  = grant_q;
               grant_d = '0;
               run_d   = 1'b0;
               dur_d   = '0;
            end else begin
               dur_d   = dur_q - DW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            run_d   = 1'b0;
         end
      endcase
   end

   // state register with synchronous reset; requester 0 wins first
   always_ff @(posedge inclk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         cnt_q   <= '0;
         dur_q   <= '0;
         last_q  <= LW'(NUM_REQ - 1);
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         dur_q   <= dur_d;
         last_q  <= last_d;
         run_q   <= run_d;
      end
   end

   assign grant           = grant_q;
   assign done            = done_q;
   assign busy            = (state_q != S_IDLE);
   assign div_clk_count   = cnt_q;
   assign div_run_n_reset = run_q;

endmodule

// File: tb/tb_div_clk_arbiter.sv
// tb_div_clk_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-timeline model.
module tb_div_clk_arbiter;

   localparam int NR = 4;
   localparam int CW = 32;
   localparam int DW = 32;

   logic             inclk = 1'b0;
   logic             Reset;
   logic [NR-1:0]    req;
   logic [NR*CW-1:0] req_div_count;
   logic [NR*DW-1:0] req_duration;
   logic [NR-1:0]    grant;
   logic [NR-1:0]    done;
   logic             busy;
   logic [CW-1:0]    div_clk_count;
   logic             div_run_n_reset;

   int n_chk = 0;
   int n_err = 0;

   // model: owner (-1 free), cycles since grant, hold length
   int            own   = -1;
   int            t     = 0;
   int            len   = 1;
   int            lastw = NR - 1;
   logic [CW-1:0] cnt_m = '0;
   logic [NR-1:0] done_m = '0;

   div_clk_arbiter #(
      .NUM_REQ(NR),
      .CW(CW),
      .DW(DW)
   ) dut (
      .inclk(inclk),
      .Reset(Reset),
      .req(req),
      .req_div_count(req_div_count),
      .req_duration(req_duration),
      .grant(grant),
      .done(done),
      .busy(busy),
      .div_clk_count(div_clk_count),
      .div_run_n_reset(div_run_n_reset)
   );

   always #5 inclk = ~inclk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int w;
      done_m = '0;
      if (Reset) begin
         own   = -1;
         t     = 0;
         lastw = NR - 1;
         cnt_m = '0;
      end else if (own < 0) begin
         if (req != '0) begin
            w = lastw;
            do w = (w + 1) % NR; while (!req[w]);
            own   = w;
            lastw = w;
            t     = 0;
            if (req_duration[w*DW +: DW] == 0) len = 1;
            else len = int'(req_duration[w*DW +: DW]);
            cnt_m = req_div_count[w*CW +: CW];
         end
      end else if (!req[own]) begin
         own = -1;
      end else begin
         t++;
         if (t > len) begin
            done_m[own] = 1'b1;
            own = -1;
         end
      end
   endtask

   task automatic step();
      logic [NR-1:0] g;
      @(posedge inclk);
      model_edge();
      #1;
      g = '0;
      if (own >= 0) g[own] = 1'b1;
      chk("grant", grant, g);
      chk("done", done, done_m);
      chk("busy", busy, own >= 0);
      chk("div_clk_count", div_clk_count, cnt_m);
      chk("run_n_reset", div_run_n_reset, own >= 0 && t >= 1);
   endtask

   initial begin
      int busy_n, run_n, seen;
      logic [NR-1:0] prev;
      logic [NR-1:0] order[$];

      Reset = 1'b1;
      req = '0;
      req_div_count = '0;
      req_duration = '0;
      step();
      step();
      Reset = 1'b0;

      // single request, count changed mid-RUN
      req_div_count[0 +: CW] = 5;
      req_duration[0 +: DW] = 10;
      req = 4'b0001;
      busy_n = 0;
      run_n = 0;
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         step();
         if (busy) busy_n++;
         if (div_run_n_reset) run_n++;
         if (c == 4) req_div_count[0 +: CW] = 9;
         if (done[0]) begin
            seen = 1;
            req = '0;
         end
      end
      chk("t1_done_seen", seen, 1);
      chk("t1_busy_cycles", busy_n, 11);
      chk("t1_run_cycles", run_n, 10);
      chk("t1_count_held", div_clk_count, 5);
      step();

      // round-robin with all requests held
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_div_count[i*CW +: CW] = i + 1;
         req_duration[i*DW +: DW] = 2;
      end
      req = '1;
      prev = '0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         step();
         if (grant != '0 && prev == '0) order.push_back(grant);
         prev = grant;
      end
      chk("rr_grants", order.size(), 5);
      for (int k = 0; k < order.size() && k < 5; k++)
         chk("rr_order", order[k], NR'(1) << (k % NR));
      req = '0;
      step();
      step();

      // abandon on RUN cycle 7
      req_duration[2*DW +: DW] = 100;
      req_div_count[2*CW +: CW] = 7;
      req = 4'b0100;
      run_n = 0;
      for (int c = 0; c < 30 && run_n < 7; c++) begin
         step();
         if (div_run_n_reset) run_n++;
      end
      chk("ab_run_reached", run_n, 7);
      req = '0;
      step();
      chk("ab_grant", grant, 0);
      chk("ab_run_n_reset", div_run_n_reset, 0);
      chk("ab_done", done, 0);
      step();

      // zero duration and zero count
      req_duration[1*DW +: DW] = 0;
      req_div_count[1*CW +: CW] = 0;
      req = 4'b0010;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         step();
         if (done[1]) seen = 1;
      end
      chk("zero_done_seen", seen, 1);
      chk("zero_count", div_clk_count, 0);
      req = '0;
      step();

      // reset during RUN, then requester 3 first
      req_duration[0 +: DW] = 20;
      req = 4'b0001;
      for (int c = 0; c < 5; c++) step();
      Reset = 1'b1;
      step();
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_run", div_run_n_reset, 0);
      chk("mid_rst_count", div_clk_count, 0);
      Reset = 1'b0;
      req = 4'b1000;
      step();
      chk("mid_rst_regrant", grant, 4'b1000);
      req = '0;
      step();
      step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         Reset = ($urandom_range(299) == 0);
         for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
               if ($urandom_range(19) == 0) req[i] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               req[i] = 1'b1;
            end
            req_div_count[i*CW +: CW] = $urandom;
            req_duration[i*DW +: DW] = $urandom_range(6);
         end
         step();
      end
      Reset = 1'b0;
      req = '0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
